trojan_mismatch_monitor: RTL and testbench
==========================================

# trojan_mismatch_monitor

- Downstream checker that sits after the Trojan-infected `top` netlist (inputs `a`, `b`, `c`, `t1`, `t2`; output `y`).
- Each valid sample compares the DUT output `y` with the golden-netlist output for the same inputs.
- Counts mismatches and trigger co-activations; captures the first divergence; raises a sticky alarm once mismatches persist.
- Used in simulation and in the on-chip Trojan-detection wrapper.

## Interface
Parameters:
- CNT_W, 16, width of saturating event counters
- PERSIST, 3, consecutive mismatching samples needed to raise alarm (legal range 1..15)
- TS_W, 32, width of sample timestamp

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  sample strobe; `y_dut`, `y_gold`, `trig` qualified by it
- y_dut  input  1  output `y` of the DUT netlist
- y_gold  input  1  output of the golden (Trojan-free) netlist
- trig  input  2  {t2, t1} candidate trigger inputs driven into the DUT
- clear  input  1  synchronous clear of alarm, counters and captures
- alarm  output  1  sticky Trojan alarm
- state  output  2  FSM state (0 CLEAN, 1 SUSPECT, 2 ALARM)
- mismatch_cnt  output  CNT_W  total mismatching samples, saturating
- trig_cnt  output  CNT_W  valid samples with trig==2'b11, saturating
- first_trig  output  2  trig value at the first mismatch since reset/clear
- first_ts  output  TS_W  sample index of the first mismatch
- first_vld  output  1  first_* fields hold a captured value

## Operation
- Mismatch: `mis = in_valid & (y_dut ^ y_gold)`. Nothing updates when in_valid=0; the streak is held.
- Sample index `ts` increments on every valid sample and saturates at all-ones. First valid sample after reset has index 0.
- `mismatch_cnt` +1 on `mis`; `trig_cnt` +1 on `in_valid & trig==2'b11`. Both saturate at 2^CNT_W-1 and never wrap.
- First capture: on `mis` while first_vld=0, latch first_trig=trig and first_ts=current index, then set first_vld=1. Later mismatches never overwrite.
- Streak counter (4 bits) tracks consecutive mismatching valid samples; a matching valid sample resets it to 0.
- FSM:
  - CLEAN --mis--> SUSPECT, streak=1. If PERSIST==1, go straight to ALARM.
  - SUSPECT --mis, streak+1==PERSIST--> ALARM.
  - SUSPECT --mis, below PERSIST--> SUSPECT, streak+1.
  - SUSPECT --valid match--> CLEAN, streak=0.
  - ALARM is absorbing until clear or reset; counters keep counting.
- `alarm` = (state==ALARM), registered.
- Clear: returns all outputs and internal state, including ts, to reset values.
- Clear asserted together with in_valid: clear wins and the sample is dropped entirely.
- Reset mid-operation behaves like clear.

## Timing
- All outputs are registered. Effects of a sample at edge N are visible after edge N, one-cycle latency.
- Reset values: alarm=0, state=0, mismatch_cnt=0, trig_cnt=0, first_trig=0, first_ts=0, first_vld=0. Internal ts=0, streak=0.
- in_valid may be asserted every cycle; there is no back-pressure.
- ALARM is entered on the edge that samples the PERSIST-th consecutive mismatch.
- Gaps in in_valid do not break a streak.

## Configuration
- `TROJAN_MON_TS_EN` defined:
  - timestamp counter is built
  - first_ts captures the sample index as above
- `TROJAN_MON_TS_EN` undefined:
  - no timestamp counter is built
  - first_ts is tied to 0
  - all other behaviour is identical, including first_trig and first_vld

## Test plan
PERSIST=3, `TROJAN_MON_TS_EN` defined.
- Reset, then matching samples trig=00, 10, 01 → state=0, alarm=0, mismatch_cnt=0, trig_cnt=0, first_vld=0.
- Samples idx0 match trig=00, idx1 match trig=10, idx2 mismatch trig=11, idx3 mismatch trig=11, idx4 mismatch trig=11 → after idx4: alarm=1, state=2, mismatch_cnt=3, trig_cnt=3, first_trig=11, first_ts=2.
- Mismatch, mismatch, match, mismatch → state ends at 1, alarm=0, mismatch_cnt=3; a valid-low gap between mismatches must not reset the streak.
- In ALARM, feed 10 matching samples → alarm stays 1. Assert clear together with a mismatching valid sample → all outputs 0 next cycle, mismatch_cnt=0.
- Preload mismatch_cnt to 2^CNT_W-1 (CNT_W=4: 15 mismatches), add 1 more → mismatch_cnt stays 15.
- Drive rst_n=0 for one cycle while in SUSPECT → all outputs at reset values next cycle. Repeat with the macro undefined → first_ts stays 0 while first_trig still captures.

Source files
------------

// File: rtl/trojan_mismatch_monitor.sv
// Compares DUT and golden netlist outputs per valid sample, counts mismatches and trigger
// co-activations, captures the first divergence and raises a sticky alarm. Macro: TROJAN_MON_TS_EN.
module trojan_mismatch_monitor #(
    parameter int CNT_W   = 16,
    parameter int PERSIST = 3,
    parameter int TS_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             y_dut,
    input  logic             y_gold,
    input  logic [1:0]       trig,
    input  logic             clear,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [1:0]       first_trig,
    output logic [TS_W-1:0]  first_ts,
    output logic             first_vld
);

    typedef enum logic [1:0] {
        CLEAN   = 2'd0,
        SUSPECT = 2'd1,
        ALARM   = 2'd2
    } state_t;

    localparam logic [3:0] PERSIST_L = 4'(PERSIST);

    state_t     st_q, st_d;
    logic [3:0] streak_q, streak_d;
    logic       mis;
    logic       rst_or_clr;

    assign mis        = in_valid & (y_dut ^ y_gold);
    assign rst_or_clr = !rst_n || clear;
    assign state      = st_q;

    always_comb begin
        st_d     = st_q;
        streak_d = streak_q;
        if (in_valid) begin
            case (st_q)
                CLEAN: begin
                    if (mis) begin
                        streak_d = 4'd1;
                        st_d     = (PERSIST == 1) ? ALARM : SUSPECT;
                    end else begin
                        streak_d = 4'd0;
                    end
                end
                SUSPECT: begin
                    if (mis) begin
                        streak_d = streak_q + 4'd1;
                        if (streak_q + 4'd1 == PERSIST_L)
                            st_d = ALARM;
                    end else begin
                        streak_d = 4'd0;
                        st_d     = CLEAN;
                    end
                end
                ALARM: begin
                    // Absorbing; streak still tracked, held at its 4-bit ceiling.
                    if (mis)
                        streak_d = (streak_q == 4'hf) ? 4'hf : streak_q + 4'd1;
                    else
                        streak_d = 4'd0;
                end
                default: begin
                    st_d     = CLEAN;
                    streak_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_or_clr) begin
            st_q         <= CLEAN;
            streak_q     <= 4'd0;
            alarm        <= 1'b0;
            mismatch_cnt <= '0;
            trig_cnt     <= '0;
            first_trig   <= 2'b00;
            first_vld    <= 1'b0;
        end else begin
            st_q     <= st_d;
            streak_q <= streak_d;
            alarm    <= (st_d == ALARM);
            if (mis && mismatch_cnt != '1)
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (in_valid && trig == 2'b11 && trig_cnt != '1)
                trig_cnt <= trig_cnt + CNT_W'(1);
            if (mis && !first_vld) begin
                first_trig <= trig;
                first_vld  <= 1'b1;
            end
        end
    end

`ifdef TROJAN_MON_TS_EN
    logic [TS_W-1:0] ts_q;

    // ts is the index of the sample being presented; it advances after each valid sample.
    always_ff @(posedge clk) begin
        if (rst_or_clr) begin
            ts_q     <= '0;
            first_ts <= '0;
        end else begin
            if (in_valid && ts_q != '1)
                ts_q <= ts_q + TS_W'(1);
            if (mis && !first_vld)
                first_ts <= ts_q;
        end
    end
`else
    assign first_ts = '0;
`endif

endmodule

// File: tb/tb_trojan_mismatch_monitor.sv
// Directed self-checking bench for trojan_mismatch_monitor (CNT_W=4, PERSIST=3).
module tb_trojan_mismatch_monitor;

    localparam int CNT_W = 4;
    localparam int TS_W  = 32;
`ifdef TROJAN_MON_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, in_valid, y_dut, y_gold, clear;
    logic [1:0]       trig;
    logic             alarm, first_vld;
    logic [1:0]       state, first_trig;
    logic [CNT_W-1:0] mismatch_cnt, trig_cnt;
    logic [TS_W-1:0]  first_ts;

    int n_chk  = 0;
    int n_fail = 0;

    trojan_mismatch_monitor #(.CNT_W(CNT_W), .PERSIST(3), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .y_dut(y_dut), .y_gold(y_gold),
        .trig(trig), .clear(clear), .alarm(alarm), .state(state),
        .mismatch_cnt(mismatch_cnt), .trig_cnt(trig_cnt), .first_trig(first_trig),
        .first_ts(first_ts), .first_vld(first_vld)
    );

    always #5 clk = ~clk;

    // {alarm, state, mismatch_cnt, trig_cnt, first_vld, first_trig}
    function automatic logic [13:0] obs();
        return {alarm, state, mismatch_cnt, trig_cnt, first_vld, first_trig};
    endfunction

    // One cycle: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic v, input logic yd, input logic yg,
                        input logic [1:0] tr, input logic clr);
        @(negedge clk);
        in_valid = v; y_dut = yd; y_gold = yg; trig = tr; clear = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] trs [3];
        trs = '{2'b00, 2'b10, 2'b01};
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        n_chk++;
        if (obs() !== 14'h0 || first_ts !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h ts=%0d, want 0000 ts=0", obs(), first_ts);
        end
        rst_n = 1'b1;
        foreach (trs[i]) step(1'b1, 1'b1, 1'b1, trs[i], 1'b0);
        n_chk++;
        if (obs() !== 14'h0) begin
            n_fail++;
            $display("FAIL match_only: got %h, want 0000", obs());
        end
    endtask

    task automatic test_detect();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        n_chk++;
        if (state !== 2'd1 || alarm !== 1'b0 || first_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL detect_idx2: state=%0d alarm=%b fv=%b, want 1 0 1", state, alarm, first_vld);
        end
        step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        n_chk++;
        if (state !== 2'd1 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL detect_idx3: state=%0d alarm=%b, want 1 0", state, alarm);
        end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        n_chk++;
        if (obs() !== {1'b1, 2'd2, 4'd3, 4'd3, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL detect_alarm: got %h, want %h", obs(), {1'b1, 2'd2, 4'd3, 4'd3, 1'b1, 2'b11});
        end
        n_chk++;
        if (first_ts !== (TS_EN ? 32'd2 : 32'd0)) begin
            n_fail++;
            $display("FAIL detect_first_ts: got %0d, want %0d", first_ts, TS_EN ? 2 : 0);
        end
    endtask

    task automatic test_alarm_hold_clear();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        n_chk++;
        if (alarm !== 1'b1 || state !== 2'd2 || mismatch_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL alarm_sticky: alarm=%b state=%0d mc=%0d, want 1 2 3", alarm, state, mismatch_cnt);
        end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
        n_chk++;
        if (obs() !== 14'h0 || first_ts !== '0) begin
            n_fail++;
            $display("FAIL clear_wins: got %h ts=%0d, want 0000 ts=0", obs(), first_ts);
        end
    endtask

    task automatic test_streak_gap();
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        n_chk++;
        if (state !== 2'd1 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_streak2: state=%0d alarm=%b, want 1 0", state, alarm);
        end
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        n_chk++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL match_to_clean: state=%0d, want 0", state);
        end
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        n_chk++;
        if (state !== 2'd1 || alarm !== 1'b0 || mismatch_cnt !== 4'd3 || first_trig !== 2'b01) begin
            n_fail++;
            $display("FAIL mmxm_end: state=%0d alarm=%b mc=%0d ft=%b, want 1 0 3 01",
                     state, alarm, mismatch_cnt, first_trig);
        end
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        n_chk++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL gap_hold: state=%0d, want 1", state);
        end
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        n_chk++;
        if (state !== 2'd2 || alarm !== 1'b1 || mismatch_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL gap_alarm: state=%0d alarm=%b mc=%0d, want 2 1 5", state, alarm, mismatch_cnt);
        end
    endtask

    task automatic test_saturate();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        n_chk++;
        if (mismatch_cnt !== 4'd15 || trig_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_reach: mc=%0d tc=%0d, want 15 15", mismatch_cnt, trig_cnt);
        end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        n_chk++;
        if (mismatch_cnt !== 4'd15 || trig_cnt !== 4'd15 || first_ts !== '0) begin
            n_fail++;
            $display("FAIL sat_hold: mc=%0d tc=%0d ts=%0d, want 15 15 0", mismatch_cnt, trig_cnt, first_ts);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        n_chk++;
        if (state !== 2'd1 || first_trig !== 2'b01 || first_ts !== (TS_EN ? 32'd1 : 32'd0)) begin
            n_fail++;
            $display("FAIL pre_reset: state=%0d ft=%b ts=%0d, want 1 01 %0d", state, first_trig, first_ts, TS_EN ? 1 : 0);
        end
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
        rst_n = 1'b1;
        n_chk++;
        if (obs() !== 14'h0 || first_ts !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h ts=%0d, want 0000 ts=0", obs(), first_ts);
        end
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        n_chk++;
        if (first_vld !== 1'b1 || first_trig !== 2'b10 || first_ts !== (TS_EN ? 32'd2 : 32'd0)) begin
            n_fail++;
            $display("FAIL post_reset_capture: fv=%b ft=%b ts=%0d, want 1 10 %0d",
                     first_vld, first_trig, first_ts, TS_EN ? 2 : 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; y_dut = 1'b0; y_gold = 1'b0; trig = 2'b00; clear = 1'b0;
        test_reset();
        test_detect();
        test_alarm_hold_clear();
        test_streak_gap();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
